adder_operand_loader: RTL and testbench

Sequential front end for the N-bit conditional-sum adder on the BASYS3 lab board. It captures operand A, then operand B and carry-in, from the switch bank on successive button strobes, and drives them onto the adder inputs. After a fixed settle interval it registers the adder's sum and carry-out, together with a signed-overflow flag and a completed-operation count, for display. It sits between the debounced button/switch logic and the adder instance, and closes the loop on the adder outputs.

---
 rtl/adder_operand_loader_pkg.sv | 15 +
 rtl/adder_operand_loader.sv | 123 ++++++++++++
 tb/tb_adder_operand_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/adder_operand_loader_pkg.sv
// Shared definitions for the conditional-sum adder lab front end:
// LED-visible FSM encodings and counter widths.
package adder_operand_loader_pkg;

    typedef enum logic [1:0] {
        STATE_LOAD_A = 2'b00,
        STATE_LOAD_B = 2'b01,
        STATE_WAIT   = 2'b10,
        STATE_SHOW   = 2'b11
    } state_e;

    localparam int OPCNT_W = 8;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/adder_operand_loader.sv
// Sequential operand loader for the external N-bit adder: captures A, then B/cin,
// waits SETTLE cycles, then latches {co,sum}, signed overflow and an operation count.
module adder_operand_loader
    import adder_operand_loader_pkg::*;
#(
    parameter int N      = 4,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       sw,
    input  logic               cin_sw,
    input  logic               btn_pulse,
    input  logic [N-1:0]       sum_in,
    input  logic               co_in,
    output logic [N-1:0]       a_out,
    output logic [N-1:0]       b_out,
    output logic               ci_out,
    output logic [N:0]         result,
    output logic               ovf,
    output logic               result_valid,
    output logic [1:0]         state_out,
    output logic [OPCNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    // Operands of equal sign whose sum changes sign have overflowed.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    state_e             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic               ci_q, ci_d;
    logic [N:0]         res_q, res_d;
    logic               ovf_q, ovf_d;
    logic               vld_q, vld_d;
    logic [OPCNT_W-1:0] opcnt_q, opcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ci_d    = ci_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        opcnt_d = opcnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            STATE_LOAD_A: begin
                if (btn_pulse) begin
                    a_d     = sw;
                    state_d = STATE_LOAD_B;
                end
            end
            STATE_LOAD_B: begin
                if (btn_pulse) begin
                    b_d     = sw;
                    ci_d    = cin_sw;
                    cnt_d   = '0;
                    state_d = STATE_WAIT;
                end
            end
            STATE_WAIT: begin
                // The strobe is deliberately ignored while the adder settles.
                if (cnt_q == CNT_LAST) begin
                    res_d   = {co_in, sum_in};
                    ovf_d   = signed_ovf(a_q[N-1], b_q[N-1], sum_in[N-1]);
                    vld_d   = 1'b1;
                    opcnt_d = opcnt_q + OPCNT_W'(1);
                    state_d = STATE_SHOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STATE_SHOW: begin
                if (btn_pulse) begin
                    vld_d   = 1'b0;
                    state_d = STATE_LOAD_A;
                end
            end
            default: state_d = STATE_LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STATE_LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            ci_q    <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            opcnt_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ci_q    <= ci_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            opcnt_q <= opcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign ci_out       = ci_q;
    assign result       = res_q;
    assign ovf          = ovf_q;
    assign result_valid = vld_q;
    assign state_out    = state_q;
    assign op_count     = opcnt_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Scoreboard bench for adder_operand_loader: the bench plays the adder, predicts each
// capture with plain integer arithmetic, and a monitor checks every result_valid rise.
module tb_adder_operand_loader;

    localparam int N      = 4;
    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sw;
    logic         cin_sw;
    logic         btn_pulse;
    logic [N-1:0] sum_in;
    logic         co_in;
    logic [N-1:0] a_out;
    logic [N-1:0] b_out;
    logic         ci_out;
    logic [N:0]   result;
    logic         ovf;
    logic         result_valid;
    logic [1:0]   state_out;
    logic [7:0]   op_count;

    adder_operand_loader #(.N(N), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .cin_sw(cin_sw), .btn_pulse(btn_pulse),
        .sum_in(sum_in), .co_in(co_in), .a_out(a_out), .b_out(b_out), .ci_out(ci_out),
        .result(result), .ovf(ovf), .result_valid(result_valid), .state_out(state_out),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // The external adder this block drives.
    assign {co_in, sum_in} = (N+1)'(a_out) + (N+1)'(b_out) + (N+1)'(ci_out);

    typedef struct {
        int unsigned res;
        int unsigned ovf;
        int unsigned cnt;
        int          bcyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   model_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every rising result_valid must match the oldest pending prediction.
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        if (result_valid === 1'b1 && prev_vld !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_capture", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", int'(result), e.res);
                chk("ovf", int'(ovf), e.ovf);
                chk("op_count", int'(op_count), e.cnt);
                chk("latency", cyc, e.bcyc + SETTLE);
            end
        end
        prev_vld = result_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        btn_pulse = 1'b1;
        tick();
        btn_pulse = 1'b0;
    endtask

    task automatic predict(input int a, input int b, input int ci);
        exp_t e;
        int sa, sb, s;
        sa = (a >= (1 << (N-1))) ? a - (1 << N) : a;
        sb = (b >= (1 << (N-1))) ? b - (1 << N) : b;
        s  = sa + sb + ci;
        model_cnt = (model_cnt + 1) % 256;
        e.res  = (a + b + ci) % (1 << (N+1));
        e.ovf  = (s > (1 << (N-1)) - 1 || s < -(1 << (N-1))) ? 1 : 0;
        e.cnt  = model_cnt;
        e.bcyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic do_op(input int a, input int b, input int ci, input bit wait_strobe, input bit dbl);
        int n;
        int bb;
        bb = dbl ? a : b;
        sw = N'(a);
        cin_sw = ci[0];
        if (dbl) begin
            btn_pulse = 1'b1;
            tick();
            tick();
            btn_pulse = 1'b0;
        end else begin
            strobe();
            chk("a_capture", int'(a_out), a);
            repeat ($urandom_range(0, 2)) tick();
            sw = N'(b);
            strobe();
        end
        predict(a, bb, ci);
        chk("a_out", int'(a_out), a);
        chk("b_out", int'(b_out), bb);
        chk("ci_out", int'(ci_out), ci);
        if (wait_strobe) begin
            strobe();
            chk("wait_ignores_strobe", int'(state_out), 2);
        end
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (result_valid !== 1'b1) chk("result_valid_timeout", 0, 1);
        repeat ($urandom_range(0, 2)) tick();
        chk("show_hold", int'(result_valid), 1);
        strobe();
        chk("show_exit_state", int'(state_out), 0);
        chk("show_exit_valid", int'(result_valid), 0);
        chk("result_held", int'(result), (a + bb + ci) % (1 << (N+1)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        btn_pulse = 1'b1;
        sw = N'($urandom);
        cin_sw = 1'b1;
        repeat (3) tick();
        chk("rst_state", int'(state_out), 0);
        chk("rst_a", int'(a_out), 0);
        chk("rst_b", int'(b_out), 0);
        chk("rst_ci", int'(ci_out), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_opcnt", int'(op_count), 0);
        btn_pulse = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_state", int'(state_out), 0);

        do_op(5, 3, 0, 1'b0, 1'b0);
        do_op(15, 1, 1, 1'b0, 1'b0);
        do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b1, 1'b0);

        // Reset one cycle after the B capture aborts the operation.
        sw = 4'd7;
        strobe();
        sw = 4'd7;
        strobe();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        model_cnt = 0;
        chk("abort_opcnt", int'(op_count), 0);
        chk("abort_state", int'(state_out), 0);
        chk("abort_valid", int'(result_valid), 0);

        do_op(int'($urandom_range(0, 15)), 0, int'($urandom_range(0, 1)), 1'b0, 1'b1);

        for (int i = 0; i < 255; i++)
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 1'b0);
        chk("opcnt_wrap", int'(op_count), 0);

        repeat (5) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
